mac_pipe: RTL
=============

// Module: mac_pipe
// PURPOSE
//  Parametrised, pipelined multiply-add/accumulate unit with valid/ready handshake.
//  Computes a*b plus either an external addend c or an internal running accumulator.
//  Flags carry-out per result, with optional saturation.
//  Sits in datapaths between a streaming source and sink (filters, dot products).
// PARAMETERS
//  A_W    18  width of unsigned operand a
//  B_W    18  width of unsigned operand b
//  ACC_W  36  width of addend c, accumulator and result; must be >= A_W+B_W
//  SAT    0   1: an overflowing result is clamped to all-ones; 0: it wraps (truncated)
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high reset
//  in_valid     in   1      input transaction valid
//  in_ready     out  1      unit accepts input this cycle
//  op           in   2      mac_pkg::mac_op_e: ADD / ACC / LOAD
//  a            in   A_W    multiplicand
//  b            in   B_W    multiplier
//  c            in   ACC_W  addend (ADD, LOAD only)
//  out_valid    out  1      result valid
//  out_ready    in   1      sink accepts result
//  result       out  ACC_W  sum after truncation or saturation
//  overflow     out  1      carry out of ACC_W bits for this result
//  ovf_sticky   out  1      OR of overflow since last LOAD or reset
// BEHAVIOUR
//  - Reset: out_valid=0, result=0, overflow=0, ovf_sticky=0, acc=0, all stage valids 0.
//  - Pipeline: S1 registers p=a*b (A_W+B_W bits), op and c. S2 registers the sum.
//    Latency is 2 cycles from accepted input to out_valid.
//  - Flow control: adv = !out_valid | out_ready; in_ready = adv, combinational.
//    Both stages load only when adv=1. A stall freezes S1 and S2 intact.
//    Throughput is 1 per cycle when the sink is always ready.
//  - Handshake: input accepted on in_valid & in_ready; output consumed on out_valid & out_ready.
//    result, overflow and out_valid stay stable while out_valid & !out_ready.
//  - S1 bubble (valid=0) moving to S2 with adv=1 clears out_valid.
//  - Sum: computed at ACC_W+1 bits, zero-extending p.
//    ADD  (2'b00): c + p; acc unchanged.
//    ACC  (2'b01): acc + p; acc <= stored result.
//    LOAD (2'b10): c + p; acc <= stored result; ovf_sticky restarts from this overflow.
//    2'b11: treated as ADD.
//  - Result and flags:
//    overflow = sum[ACC_W].
//    result = SAT && overflow ? all-ones : sum[ACC_W-1:0].
//    ovf_sticky |= overflow, for each result entering S2.
//  - Accumulator timing: acc is read and written in S2, so back-to-back ACC ops chain
//    with no hazard. acc updates only when an ACC/LOAD result enters S2.
//  - Signedness: all arithmetic is unsigned.
//  - Reset mid-operation: in-flight transactions are discarded; next cycle values equal reset values.
// STRUCTURE
//  - mac_pkg:
//    typedef enum logic [1:0] {MAC_ADD=2'b00, MAC_ACC=2'b01, MAC_LOAD=2'b10} mac_op_e;
//    localparam MAC_LATENCY = 2.
//  - Single flat module, no sub-module.
//  - Elaboration-time assertion: ACC_W >= A_W+B_W.
// TESTING (defaults unless stated)
//  1. ADD a=3 b=5 c=7, out_ready=1 -> 2 cycles later result=22, overflow=0; acc stays 0.
//  2. ADD a=b=2^18-1, c=2^36-1:
//     SAT=0 -> result=36'hFFFF80000, overflow=1, ovf_sticky=1.
//     SAT=1 -> result=36'hFFFFFFFFF.
//  3. LOAD(1,1,10), ACC(2,3), ACC(4,4) back to back -> results 11, 17, 33; acc=33.
//  4. Stream 8 ADDs (a=i, b=1, c=0) with out_ready low for cycles 3-5:
//     in_ready low while stalled; outputs 0..7 in order, none lost or duplicated.
//  5. Overflowing ADD, then LOAD(0,0,0) -> ovf_sticky=1 until the LOAD result, then 0.
//  6. Assert reset 1 cycle while out_valid=1 & out_ready=0 ->
//     next cycle out_valid=0, acc=0, ovf_sticky=0; a later ACC(1,1) -> result=1.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constants for the pipelined multiply-add/accumulate unit.
package mac_pkg;

   typedef enum logic [1:0] {
      MAC_ADD  = 2'b00,
      MAC_ACC  = 2'b01,
      MAC_LOAD = 2'b10
   } mac_op_e;

   localparam int unsigned MAC_LATENCY = 2;

endpackage

// File: rtl/mac_pipe.sv
// Two-stage multiply-add/accumulate with valid/ready flow control: S1 registers a*b,
// S2 adds c or the running accumulator and flags the carry out of ACC_W bits.
module mac_pipe
   import mac_pkg::*;
#(
   parameter int unsigned A_W   = 18,
   parameter int unsigned B_W   = 18,
   parameter int unsigned ACC_W = 36,
   parameter bit          SAT   = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  mac_op_e          op,
   input  logic [A_W-1:0]   a,
   input  logic [B_W-1:0]   b,
   input  logic [ACC_W-1:0] c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] result,
   output logic             overflow,
   output logic             ovf_sticky
);

   localparam int unsigned P_W = A_W + B_W;

   generate
      if (ACC_W < A_W + B_W) begin : g_width_check
         $error("mac_pipe: ACC_W must be at least A_W+B_W");
      end
   endgenerate

   logic             adv;
   logic             s1_valid;
   logic [P_W-1:0]   s1_p;
   mac_op_e          s1_op;
   logic [ACC_W-1:0] s1_c;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] addend;
   logic [ACC_W:0]   sum;
   logic             sum_ovf;
   logic [ACC_W-1:0] sum_res;

   // The whole pipe advances together; a full S2 that the sink refuses freezes both stages.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_p     <= '0;
         s1_op    <= MAC_ADD;
         s1_c     <= '0;
      end else if (adv) begin
         s1_valid <= in_valid;
         s1_p     <= P_W'(a) * P_W'(b);
         s1_op    <= op;
         s1_c     <= c;
      end
   end

   // NOTE: addend is given a default before the conditional override so that
   // every path assigns it and no latch is inferred.
   always_comb begin
      addend = s1_c;
      if (s1_op == MAC_ACC) begin
         addend = acc;
      end
      sum = {1'b0, addend} + (ACC_W+1)'(s1_p);
   end

   assign sum_ovf = sum[ACC_W];
   assign sum_res = (SAT && sum_ovf) ? '1 : sum[ACC_W-1:0];

   // acc is read and written in S2, so a chain of ACC ops sees each prior result in time.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         result     <= '0;
         overflow   <= 1'b0;
         ovf_sticky <= 1'b0;
         acc        <= '0;
      end else if (adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result   <= sum_res;
            overflow <= sum_ovf;
            case (s1_op)
               MAC_ACC: begin
                  acc        <= sum_res;
                  ovf_sticky <= ovf_sticky | sum_ovf;
               end
               MAC_LOAD: begin
                  acc        <= sum_res;
                  ovf_sticky <= sum_ovf;
               end
               default: begin
                  ovf_sticky <= ovf_sticky | sum_ovf;
               end
            endcase
         end
      end
   end

endmodule
